// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types and constants for the Z80 bus cycle controller.
//   cycle_t      - requested machine-cycle kind (values 5..7 are illegal)
//   bus_state_t  - T-state sequencer states
//   ILLEGAL_RDATA - read data returned for an illegal request type
package z80_bus_pkg;

  typedef enum logic [2:0] {
    CYC_FETCH  = 3'd0,
    CYC_MEM_RD = 3'd1,
    CYC_MEM_WR = 3'd2,
    CYC_IO_RD  = 3'd3,
    CYC_IO_WR  = 3'd4
  } cycle_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
  } bus_state_t;

  localparam logic [7:0] ILLEGAL_RDATA = 8'hFF;

  function automatic logic is_legal(input logic [2:0] t);
    return (t <= CYC_IO_WR);
  endfunction

  function automatic logic is_read(input logic [2:0] t);
    return (t == CYC_FETCH) || (t == CYC_MEM_RD) || (t == CYC_IO_RD);
  endfunction

  function automatic logic is_io(input logic [2:0] t);
    return (t == CYC_IO_RD) || (t == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/z80_refresh_ctr.sv
// z80_refresh_ctr: Z80 R-register style refresh address counter.
//   Exists only when Z80_RFSH_EN is defined.
//   clk    in  1  clock
//   rst    in  1  synchronous active-high reset (clears counter)
//   inc    in  1  advance the counter by one
//   r_cnt  out 8  refresh address; low RFSH_BITS bits wrap, upper bits hold
`ifdef Z80_RFSH_EN
module z80_refresh_ctr #(
  parameter int unsigned RFSH_BITS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] r_cnt
);

  localparam int unsigned LOW_MASK_INT = (1 << RFSH_BITS) - 1;
  localparam logic [7:0]  LOW_MASK     = LOW_MASK_INT[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc) begin
      // Masked merge keeps bits above RFSH_BITS untouched by the carry.
      r_cnt <= (r_cnt & ~LOW_MASK) | ((r_cnt + 8'd1) & LOW_MASK);
    end
  end

endmodule
`endif

// File: rtl/z80_bus_cycle_ctrl.sv
// z80_bus_cycle_ctrl: sequences Z80 machine cycles (fetch, memory read/write,
// I/O read/write) as T-state accurate strobes, one clk per T-state.
// Optional feature macro: Z80_RFSH_EN (refresh phase with RFSH_L and R counter).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_type/req_addr/req_wdata   request fields, registered on accept
//   rsp_valid/rsp_rdata           one-cycle completion pulse and read data
//   addr_out/data_out/data_oe     address bus, write data bus and its enable
//   data_in, WAIT_L               read data bus, active-low wait request
//   M1_L MREQ_L IORQ_L RD_L WR_L RFSH_L   registered active-low strobes
module z80_bus_cycle_ctrl
  import z80_bus_pkg::*;
#(
  parameter int unsigned IO_AUTO_WAIT = 1,
  parameter int unsigned RFSH_BITS    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  input  logic        WAIT_L,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic        RFSH_L
);

  bus_state_t state, state_nxt;
  logic [2:0] cur_type, nxt_type;
  logic [1:0] wait_cnt, wait_cnt_nxt;
  logic       accept, forced_wait, capture;
  logic       lead_ph, strobe_ph;
  logic       m1_d, mreq_d, iorq_d, rd_d, wr_d, rfsh_d, oe_d, rsp_d;

  always_comb begin
    req_ready = 1'b0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_T1:   req_ready = !is_legal(cur_type);  // illegal cycle ends in T1
      ST_T3:   req_ready = (cur_type != CYC_FETCH);
      ST_T4:   req_ready = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept      = req_valid && req_ready;
  assign nxt_type    = accept ? req_type : cur_type;
  assign forced_wait = is_io(cur_type) && (32'(wait_cnt) < IO_AUTO_WAIT);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_T1:   state_nxt = is_legal(cur_type) ? ST_T2 : ST_IDLE;
      ST_T2, ST_TW: begin
        if (forced_wait) begin
          state_nxt    = ST_TW;
          wait_cnt_nxt = wait_cnt + 2'd1;
        end else if (!WAIT_L) begin
          state_nxt = ST_TW;
        end else begin
          state_nxt = ST_T3;
        end
      end
      ST_T3:   state_nxt = (cur_type == CYC_FETCH) ? ST_T4 : ST_IDLE;
      ST_T4:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // An accepted request always overrides the return to IDLE.
    if (accept) begin
      state_nxt    = ST_T1;
      wait_cnt_nxt = '0;
    end
  end

  assign lead_ph   = (state_nxt == ST_T1) || (state_nxt == ST_T2) || (state_nxt == ST_TW);
  assign strobe_ph = (state_nxt == ST_T2) || (state_nxt == ST_TW);

  // Strobes are decoded from the state being entered so the pins are registered.
  always_comb begin
    m1_d   = 1'b1;
    mreq_d = 1'b1;
    iorq_d = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    rfsh_d = 1'b1;
    oe_d   = 1'b0;
    rsp_d  = 1'b0;
    case (nxt_type)
      CYC_FETCH: begin
        if (lead_ph) begin
          m1_d   = 1'b0;
          mreq_d = 1'b0;
          rd_d   = 1'b0;
        end
`ifdef Z80_RFSH_EN
        if (state_nxt == ST_T3) mreq_d = 1'b0;
        if ((state_nxt == ST_T3) || (state_nxt == ST_T4)) rfsh_d = 1'b0;
`endif
        rsp_d = (state_nxt == ST_T4);
      end
      CYC_MEM_RD: begin
        if (lead_ph || (state_nxt == ST_T3)) begin
          mreq_d = 1'b0;
          rd_d   = 1'b0;
        end
        rsp_d = (state_nxt == ST_T3);
      end
      CYC_MEM_WR: begin
        if (lead_ph || (state_nxt == ST_T3)) begin
          mreq_d = 1'b0;
          oe_d   = 1'b1;
        end
        if (strobe_ph) wr_d = 1'b0;
        rsp_d = (state_nxt == ST_T3);
      end
      CYC_IO_RD: begin
        if (strobe_ph) begin
          iorq_d = 1'b0;
          rd_d   = 1'b0;
        end
        rsp_d = (state_nxt == ST_T3);
      end
      CYC_IO_WR: begin
        if (strobe_ph) begin
          iorq_d = 1'b0;
          wr_d   = 1'b0;
        end
        if (lead_ph || (state_nxt == ST_T3)) oe_d = 1'b1;
        rsp_d = (state_nxt == ST_T3);
      end
      default: rsp_d = (state_nxt == ST_T1);
    endcase
  end

  assign capture = ((state == ST_T2) || (state == ST_TW)) && (state_nxt == ST_T3) &&
                   is_read(cur_type);

`ifdef Z80_RFSH_EN
  logic [7:0] r_cnt;

  z80_refresh_ctr #(.RFSH_BITS(RFSH_BITS)) u_refresh_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (state == ST_T4),
    .r_cnt (r_cnt)
  );
`else
  logic unused_rfsh_bits;
  assign unused_rfsh_bits = ^RFSH_BITS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_type  <= CYC_FETCH;
      wait_cnt  <= '0;
      M1_L      <= 1'b1;
      MREQ_L    <= 1'b1;
      IORQ_L    <= 1'b1;
      RD_L      <= 1'b1;
      WR_L      <= 1'b1;
      RFSH_L    <= 1'b1;
      data_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      addr_out  <= '0;
      data_out  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      M1_L      <= m1_d;
      MREQ_L    <= mreq_d;
      IORQ_L    <= iorq_d;
      RD_L      <= rd_d;
      WR_L      <= wr_d;
      RFSH_L    <= rfsh_d;
      data_oe   <= oe_d;
      rsp_valid <= rsp_d;
      if (accept) begin
        cur_type <= req_type;
        addr_out <= req_addr;
        data_out <= req_wdata;
        if (!is_legal(req_type)) rsp_rdata <= ILLEGAL_RDATA;
      end
      if (capture) rsp_rdata <= data_in;
`ifdef Z80_RFSH_EN
      if ((state_nxt == ST_T3) && (cur_type == CYC_FETCH)) addr_out <= {8'h00, r_cnt};
`endif
    end
  end

endmodule

// File: tb/tb_z80_bus_cycle_ctrl.sv
`timescale 1ns/1ps
module tb_z80_bus_cycle_ctrl;

  localparam int unsigned AW = 1;
`ifdef Z80_RFSH_EN
  localparam bit RFSH_ON = 1'b1;
`else
  localparam bit RFSH_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = '0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in = '0;
  logic        WAIT_L = 1'b1;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: refresh counter and last address left on the bus.
  logic [7:0]  m_rcnt = '0;
  logic [15:0] m_last_addr = '0;
  bit          m_addr_known = 1'b1;

  always #5 clk = ~clk;

  z80_bus_cycle_ctrl #(.IO_AUTO_WAIT(AW), .RFSH_BITS(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr_out(addr_out),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .WAIT_L(WAIT_L),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .RFSH_L(RFSH_L)
  );

  // Entered just after a negedge; ends at the negedge of the last T-state.
  task automatic do_txn(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                        input int unsigned w, input logic [7:0] din);
    int unsigned aw, lat, cap, first_rw;
    int unsigned n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_oe;
    int unsigned e_m1, e_mreq, e_iorq, e_rd, e_wr, e_rfsh, e_oe, e_first;
    bit          legal, fetch;
    logic [7:0]  e_rdata;
    logic [15:0] e_raddr;
    legal = (t <= 3'd4);
    fetch = (t == 3'd0);
    aw = ((t == 3'd3) || (t == 3'd4)) ? AW : 0;
    lat = !legal ? 1 : (fetch ? 4 : 3) + aw + w;
    cap = 2 + aw + w;
    e_m1 = 0; e_mreq = 0; e_iorq = 0; e_rd = 0; e_wr = 0; e_rfsh = 0; e_oe = 0; e_first = 0;
    case (t)
      3'd0: begin e_m1 = 2 + w; e_rd = 2 + w; e_mreq = 2 + w + (RFSH_ON ? 1 : 0);
                  e_rfsh = RFSH_ON ? 2 : 0; e_first = 1; end
      3'd1: begin e_mreq = 3 + w; e_rd = 3 + w; e_first = 1; end
      3'd2: begin e_mreq = 3 + w; e_wr = 1 + w; e_oe = 3 + w; e_first = 2; end
      3'd3: begin e_iorq = 1 + aw + w; e_rd = 1 + aw + w; e_first = 2; end
      3'd4: begin e_iorq = 1 + aw + w; e_wr = 1 + aw + w; e_oe = 3 + aw + w; e_first = 2; end
      default: ;
    endcase
    e_rdata = legal ? din : 8'hFF;
    e_raddr = {8'h00, m_rcnt};
    n_m1 = 0; n_mreq = 0; n_iorq = 0; n_rd = 0; n_wr = 0; n_rfsh = 0; n_oe = 0; first_rw = 0;

    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_at_req type=%0d: got %b expected 1", t, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_type = 3'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
    for (int unsigned c = 1; c <= lat; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c < 2 + aw)      WAIT_L = 1'($urandom);
      else if (c < cap)    WAIT_L = 1'b0;
      else if (c == cap)   WAIT_L = 1'b1;
      else                 WAIT_L = 1'($urandom);
      data_in = (c == cap) ? din : 8'($urandom);
      @(negedge clk);
      if (!M1_L) n_m1++;
      if (!MREQ_L) n_mreq++;
      if (!IORQ_L) n_iorq++;
      if (!RD_L) n_rd++;
      if (!WR_L) n_wr++;
      if (!RFSH_L) n_rfsh++;
      if (data_oe) n_oe++;
      if ((first_rw == 0) && (!RD_L || !WR_L)) first_rw = c;
      checks++;
      if ((rsp_valid !== (c == lat)) || (req_ready !== (c == lat))) begin
        errors++;
        $display("FAIL handshake type=%0d cyc=%0d: got rsp_valid=%b req_ready=%b expected %b",
                 t, c, rsp_valid, req_ready, (c == lat));
      end
      if ((!MREQ_L || !IORQ_L) && RFSH_L) begin
        checks++;
        if (addr_out !== a) begin
          errors++; $display("FAIL addr type=%0d cyc=%0d: got %h expected %h", t, c, addr_out, a);
        end
      end
      if (!RFSH_L) begin
        checks++;
        if (addr_out !== e_raddr) begin
          errors++; $display("FAIL rfsh_addr cyc=%0d: got %h expected %h", c, addr_out, e_raddr);
        end
      end
      if (data_oe) begin
        checks++;
        if (data_out !== wd) begin
          errors++; $display("FAIL data_out type=%0d cyc=%0d: got %h expected %h", t, c, data_out, wd);
        end
      end
      if ((c == lat) && (t != 3'd2) && (t != 3'd4)) begin
        checks++;
        if (rsp_rdata !== e_rdata) begin
          errors++; $display("FAIL rdata type=%0d: got %h expected %h", t, rsp_rdata, e_rdata);
        end
      end
    end
    checks++;
    if ({n_m1, n_mreq, n_iorq, n_rd} !== {e_m1, e_mreq, e_iorq, e_rd} ||
        {n_wr, n_rfsh, n_oe, first_rw} !== {e_wr, e_rfsh, e_oe, e_first}) begin
      errors++;
      $display("FAIL strobe_counts type=%0d w=%0d: got m1=%0d mreq=%0d iorq=%0d rd=%0d wr=%0d rfsh=%0d oe=%0d first=%0d expected %0d %0d %0d %0d %0d %0d %0d %0d",
               t, w, n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_oe, first_rw,
               e_m1, e_mreq, e_iorq, e_rd, e_wr, e_rfsh, e_oe, e_first);
    end
    if (fetch && RFSH_ON) begin
      m_last_addr = e_raddr;
      m_rcnt = {m_rcnt[7], 7'(m_rcnt[6:0] + 7'd1)};
    end else begin
      m_last_addr = a;
    end
    m_addr_known = legal;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; WAIT_L = 1'($urandom); data_in = 8'($urandom);
      @(negedge clk);
      checks++;
      if ((rsp_valid !== 1'b0) || (req_ready !== 1'b1) || (data_oe !== 1'b0) ||
          ({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L} !== 6'b111111)) begin
        errors++;
        $display("FAIL idle: got rsp_valid=%b ready=%b oe=%b strobes=%b expected 0 1 0 111111",
                 rsp_valid, req_ready, data_oe, {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L});
      end
      if (m_addr_known) begin
        checks++;
        if (addr_out !== m_last_addr) begin
          errors++; $display("FAIL idle_addr_hold: got %h expected %h", addr_out, m_last_addr);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if ({M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L} !== 6'b111111 || data_oe !== 1'b0 ||
        rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got strobes=%b oe=%b rsp_valid=%b ready=%b expected 111111 0 0 1",
               tag, {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L}, data_oe, rsp_valid, req_ready);
    end
    checks++;
    if ({addr_out, data_out, rsp_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL %s_regs: got addr=%h data=%h rdata=%h expected 0 0 0", tag, addr_out, data_out, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    m_rcnt = '0; m_last_addr = '0; m_addr_known = 1'b1;
    idle(2);
  endtask

  task automatic test_fetch();
    do_txn(3'd0, 16'h1234, 8'h00, 0, 8'h3E);
    idle(1);
  endtask

  task automatic test_mem_wr_wait();
    do_txn(3'd2, 16'h8000, 8'hA5, 3, 8'h00);
    idle(1);
  endtask

  task automatic test_io_rd();
    do_txn(3'd3, 16'h00FE, 8'h00, 0, 8'h7F);
    idle(1);
  endtask

  task automatic test_back_to_back();
    do_txn(3'd1, 16'h4000, 8'h00, 0, 8'hC3);
    do_txn(3'd2, 16'h4001, 8'h77, 0, 8'h00);
    idle(1);
  endtask

  task automatic test_reset_mid_cycle();
    req_valid = 1'b1; req_type = 3'd4; req_addr = 16'h0042; req_wdata = 8'h5A; WAIT_L = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ((IORQ_L !== 1'b0) || (WR_L !== 1'b0) || (data_oe !== 1'b1)) begin
      errors++;
      $display("FAIL io_wr_tw: got iorq=%b wr=%b oe=%b expected 0 0 1", IORQ_L, WR_L, data_oe);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_state("mid_reset");
    rst = 1'b0; WAIT_L = 1'b1;
    m_rcnt = '0; m_last_addr = '0; m_addr_known = 1'b1;
    idle(3);
  endtask

  task automatic test_refresh_fetches();
    for (int unsigned i = 0; i < 130; i++)
      do_txn(3'd0, 16'($urandom), 8'h00, $urandom_range(0, 1), 8'($urandom));
    do_txn(3'd6, 16'h1111, 8'h22, 0, 8'h00);
    idle(1);
  endtask

  task automatic test_random();
    logic [2:0] t;
    for (int unsigned i = 0; i < 80; i++) begin
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_txn(t, 16'($urandom), 8'($urandom), $urandom_range(0, 3), 8'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_mem_wr_wait();
    test_io_rd();
    test_back_to_back();
    test_reset_mid_cycle();
    test_refresh_fetches();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
